// File: rtl/snake_body.sv
// Snake body tracker: segment shift register, direction latch, wall/self collision,
// apple detection and a registered occupancy query port for the renderer.
module snake_body #(
    parameter int XW       = 6,
    parameter int YW       = 5,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         game_tick,
    input  logic [1:0]                   dir_in,
    input  logic                         dir_valid,
    input  logic                         restart,
    input  logic [XW-1:0]                apple_x,
    input  logic [YW-1:0]                apple_y,
    output logic                         ate,
    output logic                         game_over,
    output logic [XW-1:0]                head_x,
    output logic [YW-1:0]                head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    input  logic [XW-1:0]                occ_x,
    input  logic [YW-1:0]                occ_y,
    output logic                         occ_hit
);

    localparam int LW = $clog2(MAX_LEN+1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;

    typedef enum logic {RUN, DEAD} state_t;

    state_t          state_q, state_d;
    logic [1:0]      dir_q, pend_q, commit_dir;
    logic [XW-1:0]   seg_x [MAX_LEN];
    logic [YW-1:0]   seg_y [MAX_LEN];
    logic [LW-1:0]   len_q;
    logic [XW-1:0]   nx;
    logic [YW-1:0]   ny;
    logic            tick_run, wall_hit, apple_hit, self_hit, move_ok, occ_any;

    always_comb begin
        nx        = seg_x[0];
        ny        = seg_y[0];
        wall_hit  = 1'b0;
        case (pend_q)
            DIR_UP:    if (seg_y[0] == '0) wall_hit = 1'b1;
                       else ny = seg_y[0] - YW'(1);
            DIR_RIGHT: if (seg_x[0] == XW'(GRID_W-1)) wall_hit = 1'b1;
                       else nx = seg_x[0] + XW'(1);
            DIR_DOWN:  if (seg_y[0] == YW'(GRID_H-1)) wall_hit = 1'b1;
                       else ny = seg_y[0] + YW'(1);
            default:   if (seg_x[0] == '0) wall_hit = 1'b1;
                       else nx = seg_x[0] - XW'(1);
        endcase

        apple_hit = !wall_hit && (nx == apple_x) && (ny == apple_y);

        // When eating, the tail stays put, so the last live cell is also a hazard.
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (!wall_hit && seg_x[i] == nx && seg_y[i] == ny &&
                (i < int'(len_q) - 1 || (apple_hit && i < int'(len_q))))
                self_hit = 1'b1;
        end

        tick_run = game_tick && (state_q == RUN) && !reset;
        ate      = tick_run && apple_hit && !self_hit;
        move_ok  = tick_run && !wall_hit && !self_hit;

        // A request arriving on the tick edge is judged against the direction being committed.
        commit_dir = tick_run ? pend_q : dir_q;

        state_d = state_q;
        case (state_q)
            RUN:     if (tick_run && (wall_hit || self_hit)) state_d = DEAD;
            default: if (restart) state_d = RUN;
        endcase
    end

    always_comb begin
        occ_any = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q) && seg_x[i] == occ_x && seg_y[i] == occ_y)
                occ_any = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (state_q == DEAD && restart)) begin
            state_q <= RUN;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            len_q   <= LW'(INIT_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_x[i] <= XW'(GRID_W/2 - i);
                    seg_y[i] <= YW'(GRID_H/2);
                end else begin
                    seg_x[i] <= '0;
                    seg_y[i] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if (tick_run)
                dir_q <= pend_q;
            if (dir_valid && state_q == RUN && dir_in != (commit_dir ^ 2'b10))
                pend_q <= dir_in;
            if (move_ok) begin
                for (int i = MAX_LEN-1; i >= 1; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nx;
                seg_y[0] <= ny;
                if (ate && len_q != LW'(MAX_LEN))
                    len_q <= len_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) occ_hit <= 1'b0;
        else       occ_hit <= occ_any;
    end

    assign head_x    = seg_x[0];
    assign head_y    = seg_y[0];
    assign length    = len_q;
    assign game_over = (state_q == DEAD);

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: a reference snake model predicts head/length/game_over per tick,
// pushes them to exp_q, and each tick pops and compares after the edge.
module tb_snake_body;

    localparam int XW       = 6;
    localparam int YW       = 5;
    localparam int GRID_W   = 40;
    localparam int GRID_H   = 30;
    localparam int MAX_LEN  = 32;
    localparam int INIT_LEN = 3;
    localparam int LW       = $clog2(MAX_LEN+1);
    localparam int W        = 1 + XW + YW + LW;

    logic          clk, reset, game_tick, dir_valid, restart;
    logic [1:0]    dir_in;
    logic [XW-1:0] apple_x, occ_x, head_x;
    logic [YW-1:0] apple_y, occ_y, head_y;
    logic          ate, game_over, occ_hit;
    logic [LW-1:0] length;

    snake_body #(
        .XW(XW), .YW(YW), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)
    ) dut (
        .clk(clk), .reset(reset), .game_tick(game_tick), .dir_in(dir_in),
        .dir_valid(dir_valid), .restart(restart), .apple_x(apple_x), .apple_y(apple_y),
        .ate(ate), .game_over(game_over), .head_x(head_x), .head_y(head_y),
        .length(length), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    int m_x [MAX_LEN];
    int m_y [MAX_LEN];
    int m_len, m_dir, m_pend;
    bit m_dead;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_len  = INIT_LEN;
        m_dir  = 1;
        m_pend = 1;
        m_dead = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m_x[i] = (i < INIT_LEN) ? GRID_W/2 - i : 0;
            m_y[i] = (i < INIT_LEN) ? GRID_H/2 : 0;
        end
    endtask

    task automatic model_tick(input int ax, input int ay, output bit eat);
        int nx, ny, lim;
        bit hit;
        eat = 0;
        if (m_dead) return;
        m_dir = m_pend;
        nx = m_x[0];
        ny = m_y[0];
        case (m_dir)
            0: ny = ny - 1;
            1: nx = nx + 1;
            2: ny = ny + 1;
            default: nx = nx - 1;
        endcase
        if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
            m_dead = 1;
            return;
        end
        eat = (nx == ax && ny == ay);
        lim = eat ? m_len : m_len - 1;
        hit = 0;
        for (int i = 0; i < lim; i++)
            if (m_x[i] == nx && m_y[i] == ny) hit = 1;
        if (hit) begin
            m_dead = 1;
            eat = 0;
            return;
        end
        for (int i = MAX_LEN-1; i >= 1; i--) begin
            m_x[i] = m_x[i-1];
            m_y[i] = m_y[i-1];
        end
        m_x[0] = nx;
        m_y[0] = ny;
        if (eat && m_len < MAX_LEN) m_len = m_len + 1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic request_dir(input int d);
        dir_in    = 2'(d);
        dir_valid = 1'b1;
        step();
        dir_valid = 1'b0;
        if (!m_dead && d != (m_dir ^ 2)) m_pend = d;
    endtask

    task automatic do_tick(input int ax, input int ay, input string tag);
        bit eat;
        logic [W-1:0] exp, got;
        apple_x   = XW'(ax);
        apple_y   = YW'(ay);
        game_tick = 1'b1;
        model_tick(ax, ay, eat);
        exp_q.push_back({m_dead, XW'(m_x[0]), YW'(m_y[0]), LW'(m_len)});
        #1;
        tests++;
        if (ate !== eat) begin
            fails++;
            $display("FAIL %s ate: got %b want %b", tag, ate, eat);
        end
        step();
        game_tick = 1'b0;
        exp = exp_q.pop_front();
        got = {game_over, head_x, head_y, length};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s post-tick {over,x,y,len}: got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
                     tag, got[W-1], got[W-2 -: XW], got[YW+LW-1 -: YW], got[LW-1:0],
                     exp[W-1], exp[W-2 -: XW], exp[YW+LW-1 -: YW], exp[LW-1:0]);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        game_tick = 1'b1;
        dir_valid = 1'b1;
        dir_in    = 2'd0;
        apple_x   = XW'(21);
        apple_y   = YW'(15);
        step();
        step();
        tests++;
        if (ate !== 1'b0) begin fails++; $display("FAIL reset_ate: got %b want 0", ate); end
        tests++;
        if (occ_hit !== 1'b0 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: occ_hit %b game_over %b want 0 0", occ_hit, game_over);
        end
        tests++;
        if (head_x !== XW'(20) || head_y !== YW'(15) || length !== LW'(INIT_LEN)) begin
            fails++;
            $display("FAIL reset_state: head (%0d,%0d) len %0d want (20,15) len 3", head_x, head_y, length);
        end
        game_tick = 1'b0;
        dir_valid = 1'b0;
        reset     = 1'b0;
        model_reset();
        // The up request made during reset must not survive: this tick goes right.
        do_tick(0, 0, "after_reset");
    endtask

    task automatic test_move();
        apply_reset();
        do_tick(30, 0, "move");
        occ_x = XW'(19); occ_y = YW'(15);
        step();
        tests++;
        if (occ_hit !== 1'b1) begin fails++; $display("FAIL occ_body: got %b want 1", occ_hit); end
        occ_x = XW'(18);
        step();
        tests++;
        if (occ_hit !== 1'b0) begin fails++; $display("FAIL occ_vacated: got %b want 0", occ_hit); end
    endtask

    task automatic test_eat();
        apply_reset();
        do_tick(21, 15, "eat");
        occ_x = XW'(18); occ_y = YW'(15);
        step();
        tests++;
        if (occ_hit !== 1'b1 || length !== LW'(4)) begin
            fails++;
            $display("FAIL eat_tail: occ_hit %b len %0d want 1 4", occ_hit, length);
        end
    endtask

    task automatic test_reverse();
        apply_reset();
        request_dir(3);
        do_tick(0, 0, "reverse_ignored");
        request_dir(0);
        request_dir(3);
        do_tick(0, 0, "turn_up");
        tests++;
        if (head_x !== XW'(21) || head_y !== YW'(14)) begin
            fails++;
            $display("FAIL turn_head: got (%0d,%0d) want (21,14)", head_x, head_y);
        end
    endtask

    task automatic test_wall();
        apply_reset();
        for (int k = 0; k < 19; k++) do_tick(0, 0, "to_wall");
        tests++;
        if (head_x !== XW'(39) || game_over !== 1'b0) begin
            fails++;
            $display("FAIL at_wall: head_x %0d over %b want 39 0", head_x, game_over);
        end
        do_tick(0, 0, "wall_hit");
        tests++;
        if (game_over !== 1'b1) begin fails++; $display("FAIL wall_dead: got %b want 1", game_over); end
        request_dir(0);
        do_tick(39, 14, "dead_tick1");
        do_tick(39, 14, "dead_tick2");
        occ_x = XW'(39); occ_y = YW'(15);
        step();
        tests++;
        if (occ_hit !== 1'b1) begin fails++; $display("FAIL occ_dead: got %b want 1", occ_hit); end
    endtask

    task automatic test_self_hit();
        apply_reset();
        do_tick(21, 15, "grow1");
        do_tick(22, 15, "grow2");
        request_dir(2);
        do_tick(0, 0, "down");
        request_dir(3);
        do_tick(0, 0, "left");
        request_dir(0);
        do_tick(21, 15, "bite");
        tests++;
        if (game_over !== 1'b1 || length !== LW'(5)) begin
            fails++;
            $display("FAIL self_dead: over %b len %0d want 1 5", game_over, length);
        end
        occ_x = XW'(22); occ_y = YW'(16);
        step();
        tests++;
        if (occ_hit !== 1'b1) begin fails++; $display("FAIL occ_dead_body: got %b want 1", occ_hit); end
        restart   = 1'b1;
        game_tick = 1'b1;
        step();
        restart   = 1'b0;
        game_tick = 1'b0;
        model_reset();
        tests++;
        if (game_over !== 1'b0 || head_x !== XW'(20) || head_y !== YW'(15) || length !== LW'(3)) begin
            fails++;
            $display("FAIL restart_state: over %b head (%0d,%0d) len %0d want 0 (20,15) 3",
                     game_over, head_x, head_y, length);
        end
        do_tick(0, 0, "after_restart");
    endtask

    task automatic test_restart_in_run();
        apply_reset();
        do_tick(0, 0, "pre_restart");
        restart = 1'b1;
        step();
        restart = 1'b0;
        tests++;
        if (head_x !== XW'(21) || game_over !== 1'b0) begin
            fails++;
            $display("FAIL restart_run: head_x %0d over %b want 21 0", head_x, game_over);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        request_dir(0);
        for (int k = 0; k < 15; k++) do_tick(m_x[0], m_y[0] - 1, "grow_up");
        request_dir(1);
        for (int k = 0; k < 19; k++) do_tick(m_x[0] + 1, m_y[0], "grow_right");
        tests++;
        if (length !== LW'(MAX_LEN) || head_x !== XW'(39) || head_y !== YW'(0)) begin
            fails++;
            $display("FAIL saturate: len %0d head (%0d,%0d) want 32 (39,0)", length, head_x, head_y);
        end
        occ_x = XW'(20); occ_y = YW'(12);
        step();
        tests++;
        if (occ_hit !== 1'b1) begin fails++; $display("FAIL occ_last_seg: got %b want 1", occ_hit); end
        occ_y = YW'(13);
        step();
        tests++;
        if (occ_hit !== 1'b0) begin fails++; $display("FAIL occ_dropped_seg: got %b want 0", occ_hit); end
    endtask

    initial begin
        reset     = 1'b1;
        game_tick = 1'b0;
        dir_valid = 1'b0;
        dir_in    = 2'd1;
        restart   = 1'b0;
        apple_x   = '0;
        apple_y   = '0;
        occ_x     = '0;
        occ_y     = '0;
        model_reset();
        test_reset();
        test_move();
        test_eat();
        test_reverse();
        test_wall();
        test_self_hit();
        test_restart_in_run();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
